// File: rtl/bbpd_vote_accum_if.sv
// Sample/correction bundle between the sampler deserialiser, the bang-bang phase
// detector and the phase-select stage.
interface bbpd_vote_accum_if #(
  parameter int LANES = 4,
  parameter int ACC_W = 8
);
  logic                    in_valid;
  logic [LANES-1:0]        data_smp;
  logic [LANES-1:0]        edge_smp;
  logic                    up;
  logic                    down;
  logic signed [ACC_W-1:0] acc;
  logic                    no_trans;

  modport master (
    output in_valid, data_smp, edge_smp,
    input  up, down, acc, no_trans
  );

  modport slave (
    input  in_valid, data_smp, edge_smp,
    output up, down, acc, no_trans
  );
endinterface

// File: rtl/bbpd_vote_accum.sv
// Alexander bang-bang phase detector: per-lane early/late votes, a saturating signed
// vote integrator with thresholded, held-off up/down pulses, and a no-transition flag.
module bbpd_vote_accum #(
  parameter int LANES     = 4,
  parameter int ACC_W     = 8,
  parameter int THRESH    = 16,
  parameter int HOLDOFF   = 4,
  parameter int TRANS_TMO = 32
) (
  input logic              clk,
  input logic              rst,
  bbpd_vote_accum_if.slave bus
);
  localparam int CNT_W     = $clog2(LANES + 1);
  localparam int HO_W      = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
  localparam int TMO_W     = $clog2(TRANS_TMO + 1);
  localparam int SAT_MAX_I = (1 << (ACC_W - 1)) - 1;

  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(SAT_MAX_I);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-SAT_MAX_I);
  localparam logic signed [ACC_W:0] THR_POS = (ACC_W+1)'(THRESH);
  localparam logic signed [ACC_W:0] THR_NEG = (ACC_W+1)'(-THRESH);

  logic                    d_prev;
  logic                    first;
  logic                    s1_valid;
  logic [CNT_W-1:0]        s1_up;
  logic [CNT_W-1:0]        s1_dn;
  logic signed [ACC_W-1:0] acc_q;
  logic                    up_q;
  logic                    down_q;
  logic [HO_W-1:0]         holdoff;
  logic [TMO_W-1:0]        tmo_cnt;

  logic [LANES-1:0] prev_bits;
  logic [LANES-1:0] trans;
  logic [LANES-1:0] vote_up;
  logic [LANES-1:0] vote_dn;
  logic [CNT_W-1:0] cnt_up;
  logic [CNT_W-1:0] cnt_dn;

  // Each lane compares against the UI before it; lane 0 looks back into the prior word.
  always_comb begin
    prev_bits = {bus.data_smp[LANES-2:0], d_prev};
    trans     = (prev_bits ^ bus.data_smp) & {{(LANES-1){1'b1}}, ~first};
    vote_up   = trans & ~(bus.edge_smp ^ bus.data_smp);
    vote_dn   = trans &  (bus.edge_smp ^ bus.data_smp);
    cnt_up    = '0;
    cnt_dn    = '0;
    for (int i = 0; i < LANES; i++) begin
      cnt_up = cnt_up + CNT_W'(vote_up[i]);
      cnt_dn = cnt_dn + CNT_W'(vote_dn[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_up    <= '0;
      s1_dn    <= '0;
      d_prev   <= 1'b0;
      first    <= 1'b1;
      tmo_cnt  <= '0;
    end else begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_up  <= cnt_up;
        s1_dn  <= cnt_dn;
        d_prev <= bus.data_smp[LANES-1];
        first  <= 1'b0;
        if (|trans)
          tmo_cnt <= '0;
        else if (tmo_cnt != TMO_W'(TRANS_TMO))
          tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
    end
  end

  logic signed [ACC_W:0] up_ext;
  logic signed [ACC_W:0] dn_ext;
  logic signed [ACC_W:0] net;
  logic signed [ACC_W:0] sum_raw;
  logic signed [ACC_W:0] sum_sat;

  // One extra bit of headroom lets the clamp see overflow before it would wrap acc.
  always_comb begin
    up_ext  = $signed({{(ACC_W+1-CNT_W){1'b0}}, s1_up});
    dn_ext  = $signed({{(ACC_W+1-CNT_W){1'b0}}, s1_dn});
    net     = up_ext - dn_ext;
    sum_raw = $signed({acc_q[ACC_W-1], acc_q}) + net;
    if (sum_raw > SAT_MAX)
      sum_sat = SAT_MAX;
    else if (sum_raw < SAT_MIN)
      sum_sat = SAT_MIN;
    else
      sum_sat = sum_raw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      holdoff <= '0;
    end else begin
      up_q   <= 1'b0;
      down_q <= 1'b0;
      if (holdoff != '0)
        holdoff <= holdoff - HO_W'(1);
      if (s1_valid) begin
        if (holdoff == '0 && sum_sat >= THR_POS) begin
          up_q    <= 1'b1;
          acc_q   <= '0;
          holdoff <= HO_W'(HOLDOFF);
        end else if (holdoff == '0 && sum_sat <= THR_NEG) begin
          down_q  <= 1'b1;
          acc_q   <= '0;
          holdoff <= HO_W'(HOLDOFF);
        end else begin
          acc_q <= sum_sat[ACC_W-1:0];
        end
      end
    end
  end

  assign bus.up       = up_q;
  assign bus.down     = down_q;
  assign bus.acc      = acc_q;
  assign bus.no_trans = (tmo_cnt == TMO_W'(TRANS_TMO));

endmodule

// File: tb/tb_bbpd_vote_accum.sv
// Directed bench for bbpd_vote_accum: one small-threshold instance for pulse timing and
// one high-threshold, long hold-off instance for saturation.
module tb_bbpd_vote_accum;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bbpd_vote_accum_if #(.LANES(4), .ACC_W(8)) if1 ();
  bbpd_vote_accum_if #(.LANES(4), .ACC_W(8)) if2 ();

  bbpd_vote_accum #(.LANES(4), .ACC_W(8), .THRESH(8), .HOLDOFF(4), .TRANS_TMO(16)) u_dut (
    .clk(clk), .rst(rst), .bus(if1)
  );

  bbpd_vote_accum #(.LANES(4), .ACC_W(8), .THRESH(120), .HOLDOFF(255), .TRANS_TMO(16)) u_dut_sat (
    .clk(clk), .rst(rst), .bus(if2)
  );

  task automatic step1(input logic v, input logic [3:0] d, input logic [3:0] e);
    if1.in_valid = v; if1.data_smp = d; if1.edge_smp = e;
    @(posedge clk); #1;
  endtask

  task automatic step2(input logic v, input logic [3:0] d, input logic [3:0] e);
    if2.in_valid = v; if2.data_smp = d; if2.edge_smp = e;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    if1.in_valid = 1'b0; if2.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    step1(1, 4'b0000, 4'b0000);
    step1(1, 4'b0101, 4'b0101);
    step1(1, 4'b0101, 4'b0101);
    rst = 1'b1;
    step1(1, 4'b0101, 4'b0101);
    rst = 1'b0;
    checks++; if (if1.acc !== 8'sd0) begin errors++; $display("FAIL reset_acc got %0d exp 0", $signed(if1.acc)); end
    checks++; if (if1.up !== 1'b0) begin errors++; $display("FAIL reset_up got %b exp 0", if1.up); end
    checks++; if (if1.down !== 1'b0) begin errors++; $display("FAIL reset_down got %b exp 0", if1.down); end
    checks++; if (if1.no_trans !== 1'b0) begin errors++; $display("FAIL reset_no_trans got %b exp 0", if1.no_trans); end
  endtask

  task automatic test_no_trans();
    logic exp_nt;
    do_reset();
    for (int k = 1; k <= 18; k++) begin
      step1(1, 4'b0000, 4'b0000);
      exp_nt = (k >= 16);
      checks++; if (if1.no_trans !== exp_nt) begin errors++; $display("FAIL no_trans_word%0d got %b exp %b", k, if1.no_trans, exp_nt); end
      checks++; if (if1.acc !== 8'sd0 || if1.up !== 1'b0 || if1.down !== 1'b0) begin
        errors++; $display("FAIL quiet_word%0d got acc=%0d up=%b dn=%b exp 0 0 0", k, $signed(if1.acc), if1.up, if1.down);
      end
    end
    if1.in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (if1.no_trans !== 1'b1) begin errors++; $display("FAIL no_trans_gap got %b exp 1", if1.no_trans); end
    step1(1, 4'b0001, 4'b0001);
    checks++; if (if1.no_trans !== 1'b0) begin errors++; $display("FAIL no_trans_clear got %b exp 0", if1.no_trans); end
  endtask

  task automatic test_votes(input bit mirror);
    int exp_acc[10] = '{0, 4, 0, 4, 8, 12, 16, 0, 4, 8};
    logic exp_p;
    logic [7:0] exp_a;
    do_reset();
    step1(1, 4'b0000, 4'b0000);
    for (int k = 0; k < 10; k++) begin
      step1(1, 4'b0101, mirror ? 4'b1010 : 4'b0101);
      exp_p = (k == 2 || k == 7);
      exp_a = mirror ? 8'(-exp_acc[k]) : 8'(exp_acc[k]);
      checks++; if (if1.acc !== exp_a) begin errors++; $display("FAIL votes_m%0d_acc%0d got %0d exp %0d", mirror, k, $signed(if1.acc), $signed(exp_a)); end
      checks++; if (if1.up !== (mirror ? 1'b0 : exp_p)) begin errors++; $display("FAIL votes_m%0d_up%0d got %b exp %b", mirror, k, if1.up, mirror ? 1'b0 : exp_p); end
      checks++; if (if1.down !== (mirror ? exp_p : 1'b0)) begin errors++; $display("FAIL votes_m%0d_dn%0d got %b exp %b", mirror, k, if1.down, mirror ? exp_p : 1'b0); end
    end
    checks++; if (if1.no_trans !== 1'b0) begin errors++; $display("FAIL votes_m%0d_no_trans got %b exp 0", mirror, if1.no_trans); end
  endtask

  task automatic test_saturation();
    int ups = 0, downs = 0, up_at = 0, neg = 0;
    do_reset();
    step2(1, 4'b0000, 4'b0000);
    for (int k = 1; k <= 100; k++) begin
      step2(1, 4'b0101, 4'b0101);
      if (if2.up) begin ups++; up_at = k; end
      if (if2.down) downs++;
      if (if2.acc[7]) neg++;
      if (k == 30) begin
        checks++; if (if2.acc !== 8'sd116) begin errors++; $display("FAIL sat_pre_pulse got %0d exp 116", $signed(if2.acc)); end
      end
      if (k == 62) begin
        checks++; if (if2.acc !== 8'sd124) begin errors++; $display("FAIL sat_climb got %0d exp 124", $signed(if2.acc)); end
      end
    end
    if2.in_valid = 1'b0;
    checks++; if (ups !== 1) begin errors++; $display("FAIL sat_up_count got %0d exp 1", ups); end
    checks++; if (up_at !== 31) begin errors++; $display("FAIL sat_up_time got %0d exp 31", up_at); end
    checks++; if (downs !== 0) begin errors++; $display("FAIL sat_down_count got %0d exp 0", downs); end
    checks++; if (neg !== 0) begin errors++; $display("FAIL sat_negative got %0d exp 0", neg); end
    checks++; if (if2.acc !== 8'sd127) begin errors++; $display("FAIL sat_hold got %0d exp 127", $signed(if2.acc)); end
  endtask

  task automatic test_reset_midstream();
    int exp_acc[4] = '{0, 3, 7, 0};
    do_reset();
    step1(1, 4'b0000, 4'b0000);
    step1(1, 4'b0101, 4'b0101);
    step1(1, 4'b0101, 4'b0101);
    checks++; if (if1.acc !== 8'sd4) begin errors++; $display("FAIL mid_pre_acc got %0d exp 4", $signed(if1.acc)); end
    rst = 1'b1;
    step1(1, 4'b0101, 4'b0101);
    rst = 1'b0;
    checks++; if (if1.acc !== 8'sd0 || if1.up !== 1'b0 || if1.down !== 1'b0) begin
      errors++; $display("FAIL mid_rst got acc=%0d up=%b dn=%b exp 0 0 0", $signed(if1.acc), if1.up, if1.down);
    end
    for (int k = 0; k < 4; k++) begin
      step1(1, 4'b0101, 4'b0101);
      checks++; if (if1.acc !== 8'(exp_acc[k])) begin errors++; $display("FAIL mid_acc%0d got %0d exp %0d", k, $signed(if1.acc), exp_acc[k]); end
      checks++; if (if1.up !== (k == 3)) begin errors++; $display("FAIL mid_up%0d got %b exp %b", k, if1.up, k == 3); end
    end
  endtask

  task automatic test_valid_gaps();
    int exp_acc[10] = '{0, 4, 4, 0, 0, 4, 4, 8, 8, 0};
    logic v;
    do_reset();
    step1(1, 4'b0000, 4'b0000);
    for (int k = 0; k < 10; k++) begin
      v = (k % 2 == 0);
      if (v) step1(1, 4'b0101, 4'b0101);
      else   step1(0, 4'b1111, 4'b0000);
      checks++; if (if1.acc !== 8'(exp_acc[k])) begin errors++; $display("FAIL gap_acc%0d got %0d exp %0d", k, $signed(if1.acc), exp_acc[k]); end
      checks++; if (if1.up !== (k == 3 || k == 9)) begin errors++; $display("FAIL gap_up%0d got %b exp %b", k, if1.up, k == 3 || k == 9); end
      checks++; if (if1.down !== 1'b0) begin errors++; $display("FAIL gap_dn%0d got %b exp 0", k, if1.down); end
    end
  endtask

  initial begin
    if1.in_valid = 1'b0; if1.data_smp = '0; if1.edge_smp = '0;
    if2.in_valid = 1'b0; if2.data_smp = '0; if2.edge_smp = '0;
    $display("[TB] bbpd_vote_accum directed tests");
    test_reset();
    test_no_trans();
    test_votes(1'b0);
    test_votes(1'b1);
    test_saturation();
    test_reset_midstream();
    test_valid_gaps();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired got timeout exp completion");
    $fatal(1, "[TB] watchdog");
  end
endmodule
